// File: rtl/snake_pkg.sv
// Shared types for the snake game core.
//   dir_t       : movement direction. The encoding makes each direction's
//                 reverse equal to the code with bit 1 flipped.
//   state_t     : game FSM states.
//   reverse_dir : returns the opposite direction.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    LEFT  = 2'd1,
    DOWN  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    SCAN = 3'd2,
    MOVE = 3'd3,
    DEAD = 3'd4
  } state_t;

  // UP<->DOWN and LEFT<->RIGHT differ only in bit 1.
  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_if.sv
// Pixel-query bus between the VGA renderer (master) and the snake engine
// (slave).
//   q_cx, q_cy         : cell being drawn (master -> slave)
//   head_hit, body_hit : cell holds the head / a body segment (slave -> master)
// The bus has no valid/ready pair: the master presents a cell every cycle
// and the slave answers that cell exactly one cycle later.
interface snake_if #(
  parameter int CX_W = 6,
  parameter int CY_W = 6
);
  logic [CX_W-1:0] q_cx;
  logic [CY_W-1:0] q_cy;
  logic            head_hit;
  logic            body_hit;

  modport master (output q_cx, q_cy, input head_hit, body_hit);
  modport slave  (input q_cx, q_cy, output head_hit, body_hit);
endinterface

// File: rtl/snake_dir_ctrl.sv
// Direction filter for the snake.
//   master_clk, reset_n : clock, async active-low reset
//   clr                 : synchronous return to RIGHT with no pending request
//   up/left/down/right  : button levels
//   apply               : the update tick is being taken this cycle
//   len_gt1             : snake is longer than one segment (reversal is banned)
//   dir_eff             : direction to use if the step is taken this cycle
// A one-hot, non-reversing button pattern becomes the pending request; the
// latest one wins. A request present in the tick cycle itself overrides the
// stored one. The pending request is re-checked at the tick because the
// snake may have grown since it was captured.
module snake_dir_ctrl
  import snake_pkg::*;
(
  input  logic master_clk,
  input  logic reset_n,
  input  logic clr,
  input  logic up,
  input  logic left,
  input  logic down,
  input  logic right,
  input  logic apply,
  input  logic len_gt1,
  output dir_t dir_eff
);

  dir_t dir;
  dir_t req_d;
  dir_t pend_d;
  logic req_v;
  logic req_ok;
  logic pend_v;
  logic pend_ok;

  always_comb begin
    req_v = 1'b1;
    req_d = UP;
    case ({right, down, left, up})
      4'b0001: req_d = UP;
      4'b0010: req_d = LEFT;
      4'b0100: req_d = DOWN;
      4'b1000: req_d = RIGHT;
      default: req_v = 1'b0;
    endcase
  end

  assign req_ok  = req_v  && !(len_gt1 && (req_d  == reverse_dir(dir)));
  assign pend_ok = pend_v && !(len_gt1 && (pend_d == reverse_dir(dir)));
  assign dir_eff = req_ok ? req_d : (pend_ok ? pend_d : dir);

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      dir    <= RIGHT;
      pend_v <= 1'b0;
      pend_d <= RIGHT;
    end else if (clr) begin
      dir    <= RIGHT;
      pend_v <= 1'b0;
      pend_d <= RIGHT;
    end else if (apply) begin
      dir    <= dir_eff;
      pend_v <= 1'b0;
    end else if (req_ok) begin
      pend_v <= 1'b1;
      pend_d <= req_d;
    end
  end

endmodule

// File: rtl/snake_engine.sv
// Snake game-logic core: segment store, step FSM, collision scan, pixel query.
//   master_clk, reset_n : clock, async active-low reset
//   start               : low holds the game in IDLE (synchronous clear)
//   tick                : one-cycle update strobe
//   up/left/down/right  : button levels
//   apple_cx/apple_cy   : apple cell, sampled when a step is decided
//   qry                 : pixel-query bus (slave side), 1-cycle latency
//   apple_eaten         : one-cycle pulse during MOVE when the head eats
//   game_over           : high in DEAD
//   length              : current segment count
//   busy                : high in SCAN/MOVE
//   state_dbg           : current FSM state
module snake_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int GRID_W  = 64,
  parameter int GRID_H  = 48,
  parameter int CX_W    = 6,
  parameter int CY_W    = 6,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic             master_clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             tick,
  input  logic             up,
  input  logic             left,
  input  logic             down,
  input  logic             right,
  input  logic [CX_W-1:0]  apple_cx,
  input  logic [CY_W-1:0]  apple_cy,
  snake_if.slave           qry,
  output logic             apple_eaten,
  output logic             game_over,
  output logic [LEN_W-1:0] length,
  output logic             busy,
  output state_t           state_dbg
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [CX_W:0]    X_ONE   = (CX_W+1)'(1);
  localparam logic [CY_W:0]    Y_ONE   = (CY_W+1)'(1);
  localparam logic [CX_W:0]    X_LAST  = (CX_W+1)'(GRID_W - 1);
  localparam logic [CY_W:0]    Y_LAST  = (CY_W+1)'(GRID_H - 1);
  localparam logic [CX_W-1:0]  X_HOME  = CX_W'(GRID_W / 2);
  localparam logic [CY_W-1:0]  Y_HOME  = CY_W'(GRID_H / 2);

  state_t           state;
  dir_t             dir_eff;
  logic [CX_W-1:0]  seg_x [MAX_LEN];
  logic [CY_W-1:0]  seg_y [MAX_LEN];
  logic [CX_W:0]    nh_x;      // one bit wider so the border test sees underflow
  logic [CY_W:0]    nh_y;
  logic [CX_W:0]    step_x;
  logic [CY_W:0]    step_y;
  logic             apple_hit;
  logic [IDX_W-1:0] scan_idx;
  logic [LEN_W-1:0] scan_cnt;  // segments to compare; 0 is legal (length 1)
  logic             step_now;
  logic             step_apple;
  logic             nh_border;
  logic             seg_match;
  logic             scan_done;
  logic             q_head;
  logic             q_body;

  assign state_dbg = state;
  assign step_now  = start && (state == RUN) && tick;

  snake_dir_ctrl u_dir (
    .master_clk (master_clk),
    .reset_n    (reset_n),
    .clr        (!start),
    .up         (up),
    .left       (left),
    .down       (down),
    .right      (right),
    .apply      (step_now),
    .len_gt1    (length > LEN_ONE),
    .dir_eff    (dir_eff)
  );

  always_comb begin
    step_x = {1'b0, seg_x[0]};
    step_y = {1'b0, seg_y[0]};
    case (dir_eff)
      UP:      step_y = {1'b0, seg_y[0]} - Y_ONE;
      DOWN:    step_y = {1'b0, seg_y[0]} + Y_ONE;
      LEFT:    step_x = {1'b0, seg_x[0]} - X_ONE;
      default: step_x = {1'b0, seg_x[0]} + X_ONE;
    endcase
  end

  assign step_apple = (step_x == {1'b0, apple_cx}) && (step_y == {1'b0, apple_cy});
  assign nh_border  = (nh_x == '0) || (nh_x >= X_LAST) || (nh_y == '0) || (nh_y >= Y_LAST);
  assign seg_match  = (LEN_W'(scan_idx) < scan_cnt) &&
                      ({1'b0, seg_x[scan_idx]} == nh_x) && ({1'b0, seg_y[scan_idx]} == nh_y);
  assign scan_done  = (LEN_W'(scan_idx) + LEN_ONE) >= scan_cnt;

  always_comb begin
    q_head = (seg_x[0] == qry.q_cx) && (seg_y[0] == qry.q_cy);
    q_body = 1'b0;
    for (int k = 1; k < MAX_LEN; k++) begin
      if ((LEN_W'(k) < length) && (seg_x[k] == qry.q_cx) && (seg_y[k] == qry.q_cy)) begin
        q_body = 1'b1;
      end
    end
  end

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      length      <= LEN_ONE;
      nh_x        <= '0;
      nh_y        <= '0;
      apple_hit   <= 1'b0;
      scan_idx    <= '0;
      scan_cnt    <= '0;
      apple_eaten <= 1'b0;
      game_over   <= 1'b0;
      busy        <= 1'b0;
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x[k] <= (k == 0) ? X_HOME : '0;
        seg_y[k] <= (k == 0) ? Y_HOME : '0;
      end
    end else if (!start) begin
      state       <= IDLE;
      length      <= LEN_ONE;
      nh_x        <= '0;
      nh_y        <= '0;
      apple_hit   <= 1'b0;
      scan_idx    <= '0;
      scan_cnt    <= '0;
      apple_eaten <= 1'b0;
      game_over   <= 1'b0;
      busy        <= 1'b0;
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x[k] <= (k == 0) ? X_HOME : '0;
        seg_y[k] <= (k == 0) ? Y_HOME : '0;
      end
    end else begin
      apple_eaten <= 1'b0;
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (tick) begin
            nh_x      <= step_x;
            nh_y      <= step_y;
            apple_hit <= step_apple;
            scan_idx  <= '0;
            // A growing snake keeps its tail, so the tail cell must be scanned.
            scan_cnt  <= (step_apple && (length < LEN_MAX)) ? length : length - LEN_ONE;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (nh_border || seg_match) begin
            busy      <= 1'b0;
            game_over <= 1'b1;
            state     <= DEAD;
          end else if (scan_done) begin
            apple_eaten <= apple_hit;
            state       <= MOVE;
          end else begin
            scan_idx <= scan_idx + IDX_ONE;
          end
        end
        MOVE: begin
          // Shifting every slot is harmless: slots at or beyond length are
          // masked out of the query and the scan.
          for (int k = 1; k < MAX_LEN; k++) begin
            seg_x[k] <= seg_x[k-1];
            seg_y[k] <= seg_y[k-1];
          end
          seg_x[0] <= nh_x[CX_W-1:0];
          seg_y[0] <= nh_y[CY_W-1:0];
          if (apple_hit && (length < LEN_MAX)) length <= length + LEN_ONE;
          busy  <= 1'b0;
          state <= RUN;
        end
        DEAD: state <= DEAD;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      qry.head_hit <= 1'b0;
      qry.body_hit <= 1'b0;
    end else if (!start || (state == IDLE)) begin
      qry.head_hit <= 1'b0;
      qry.body_hit <= 1'b0;
    end else begin
      qry.head_hit <= q_head;
      qry.body_hit <= q_body;
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
module tb_snake_engine;
  import snake_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int GRID_W  = 64;
  localparam int GRID_H  = 48;
  localparam int CX_W    = 6;
  localparam int CY_W    = 6;
  localparam int LEN_W   = 5;

  // ---------------- clock / reset / DUT ----------------
  logic             master_clk = 1'b0;
  logic             reset_n    = 1'b0;
  logic             start      = 1'b0;
  logic             tick       = 1'b0;
  logic             up = 1'b0, left = 1'b0, down = 1'b0, right = 1'b0;
  logic [CX_W-1:0]  apple_cx = '0;
  logic [CY_W-1:0]  apple_cy = '0;
  logic             apple_eaten;
  logic             game_over;
  logic             busy;
  logic [LEN_W-1:0] length;
  state_t           state_dbg;

  snake_if #(.CX_W(CX_W), .CY_W(CY_W)) qry ();

  snake_engine #(
    .MAX_LEN (MAX_LEN),
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H),
    .CX_W    (CX_W),
    .CY_W    (CY_W)
  ) dut (
    .master_clk  (master_clk),
    .reset_n     (reset_n),
    .start       (start),
    .tick        (tick),
    .up          (up),
    .left        (left),
    .down        (down),
    .right       (right),
    .apple_cx    (apple_cx),
    .apple_cy    (apple_cy),
    .qry         (qry),
    .apple_eaten (apple_eaten),
    .game_over   (game_over),
    .length      (length),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  always #5 master_clk = ~master_clk;

  // ---------------- scoreboard state ----------------
  int checks  = 0;
  int errors  = 0;
  int eat_cnt = 0;
  int eat_bad = 0;
  int gap     = 1000;

  // Counts apple_eaten pulses; every pulse must coincide with MOVE.
  always @(negedge master_clk) begin
    if (apple_eaten) begin
      eat_cnt++;
      if (state_dbg != MOVE) eat_bad++;
    end
  end

  // Tick spacing must respect the integration guarantee.
  always @(posedge master_clk) begin
    if (tick) begin
      if (gap < MAX_LEN + 2) begin
        errors++;
        $display("FAIL tick_spacing: got gap %0d required >= %0d", gap + 1, MAX_LEN + 3);
      end
      gap = 0;
    end else begin
      gap++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int x;
    int y;
    int eh;
    int eb;
  } qv_t;

  typedef struct {
    logic [3:0] btn;  // {right, down, left, up}
    int         hx;
    int         hy;
  } dv_t;

  qv_t qtab[$];
  dv_t dtab[$];

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge master_clk);
  endtask

  task automatic set_btn(input logic [3:0] b);
    {right, down, left, up} = b;
  endtask

  task automatic set_apple(input int x, input int y);
    apple_cx = CX_W'(x);
    apple_cy = CY_W'(y);
  endtask

  task automatic do_tick();
    int n;
    tick = 1'b1;
    @(negedge master_clk);
    tick = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      @(negedge master_clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: busy still 1 after %0d cycles, required 0", n);
    end
    cyc(20);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic restart();
    start = 1'b0;
    cyc(2);
    start = 1'b1;
    cyc(20);
  endtask

  task automatic q_chk(input string name, input int x, input int y, input int eh, input int eb);
    qry.q_cx = CX_W'(x);
    qry.q_cy = CY_W'(y);
    @(negedge master_clk);
    chk({name, ".head"}, int'(qry.head_hit), eh);
    chk({name, ".body"}, int'(qry.body_hit), eb);
  endtask

  task automatic run_qtab(input string name);
    for (int i = 0; i < qtab.size(); i++)
      q_chk($sformatf("%s[%0d]", name, i), qtab[i].x, qtab[i].y, qtab[i].eh, qtab[i].eb);
    qtab.delete();
  endtask

  // ---------------- test sequence ----------------
  int eat0;

  initial begin
    qry.q_cx = '0;
    qry.q_cy = '0;
    cyc(3);
    reset_n = 1'b1;
    cyc(2);

    // Reset state
    chk("rst.length", int'(length), 1);
    chk("rst.game_over", int'(game_over), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.apple_eaten", int'(apple_eaten), 0);
    chk("rst.state", int'(state_dbg), int'(IDLE));
    q_chk("rst.q_home_idle", 32, 24, 0, 0);
    do_tick();
    chk("idle.tick_dropped", int'(state_dbg), int'(IDLE));

    // Test 1: three steps right, no apple
    start = 1'b1;
    set_btn(4'b1000);
    cyc(20);
    chk("t1.run", int'(state_dbg), int'(RUN));
    eat0 = eat_cnt;
    ticks(3);
    chk("t1.length", int'(length), 1);
    chk("t1.no_eat", eat_cnt - eat0, 0);
    qtab.push_back('{35, 24, 1, 0});
    qtab.push_back('{34, 24, 0, 0});
    qtab.push_back('{32, 24, 0, 0});
    run_qtab("t1.q");

    // Test 2: eat one apple
    restart();
    eat0 = eat_cnt;
    set_apple(33, 24);
    do_tick();
    set_apple(0, 0);
    chk("t2.eat_pulse", eat_cnt - eat0, 1);
    chk("t2.length", int'(length), 2);
    qtab.push_back('{33, 24, 1, 0});
    qtab.push_back('{32, 24, 0, 1});
    qtab.push_back('{31, 24, 0, 0});
    run_qtab("t2.q");

    // Test 3: run into the right border at (63,10)
    restart();
    set_btn(4'b0001);
    ticks(14);
    set_btn(4'b1000);
    ticks(30);
    chk("t3.alive", int'(game_over), 0);
    q_chk("t3.pre", 62, 10, 1, 0);
    do_tick();
    chk("t3.game_over", int'(game_over), 1);
    chk("t3.state", int'(state_dbg), int'(DEAD));
    q_chk("t3.dead_head", 62, 10, 1, 0);
    ticks(2);
    chk("t3.still_dead", int'(state_dbg), int'(DEAD));
    chk("t3.still_over", int'(game_over), 1);
    q_chk("t3.frozen", 62, 10, 1, 0);

    // Test 4a: length 4 chasing its tail survives
    restart();
    set_btn(4'b1000);
    for (int i = 0; i < 3; i++) begin
      set_apple(33 + i, 24);
      do_tick();
    end
    set_apple(0, 0);
    chk("t4a.length", int'(length), 4);
    set_btn(4'b0100); do_tick();
    set_btn(4'b0010); do_tick();
    set_btn(4'b0001); do_tick();
    set_btn(4'b1000); do_tick();
    chk("t4a.alive", int'(game_over), 0);
    chk("t4a.state", int'(state_dbg), int'(RUN));
    chk("t4a.length_kept", int'(length), 4);
    qtab.push_back('{35, 24, 1, 0});
    qtab.push_back('{34, 24, 0, 1});
    qtab.push_back('{34, 25, 0, 1});
    qtab.push_back('{35, 25, 0, 1});
    qtab.push_back('{33, 24, 0, 0});
    run_qtab("t4a.q");

    // Test 5: direction filter, length 4 moving right from (35,24)
    dtab.push_back('{4'b0010, 36, 24});  // reverse ignored
    dtab.push_back('{4'b0011, 37, 24});  // multi-hot ignored
    dtab.push_back('{4'b0000, 38, 24});  // none pressed
    dtab.push_back('{4'b0100, 38, 25});  // turn down
    dtab.push_back('{4'b0001, 38, 26});  // reverse of down ignored
    dtab.push_back('{4'b1100, 38, 27});  // multi-hot ignored
    for (int i = 0; i < dtab.size(); i++) begin
      set_btn(dtab[i].btn);
      do_tick();
      q_chk($sformatf("t5.dir[%0d]", i), dtab[i].hx, dtab[i].hy, 1, 0);
      chk($sformatf("t5.alive[%0d]", i), int'(game_over), 0);
    end

    // Test 6a: start low in the middle of a scan
    set_btn(4'b0000);
    tick = 1'b1;
    @(negedge master_clk);
    tick = 1'b0;
    chk("t6a.in_scan", int'(state_dbg), int'(SCAN));
    start = 1'b0;
    @(negedge master_clk);
    chk("t6a.idle", int'(state_dbg), int'(IDLE));
    chk("t6a.length", int'(length), 1);
    chk("t6a.busy", int'(busy), 0);
    start = 1'b1;
    cyc(20);
    q_chk("t6a.home", 32, 24, 1, 0);
    q_chk("t6a.old_gone", 38, 27, 0, 0);

    // Test 4b: length 5 loop bites itself
    restart();
    set_btn(4'b1000);
    for (int i = 0; i < 4; i++) begin
      set_apple(33 + i, 24);
      do_tick();
    end
    set_apple(0, 0);
    chk("t4b.length", int'(length), 5);
    set_btn(4'b0100); do_tick();
    set_btn(4'b0010); do_tick();
    chk("t4b.alive_before", int'(game_over), 0);
    set_btn(4'b0001); do_tick();
    chk("t4b.game_over", int'(game_over), 1);
    chk("t4b.state", int'(state_dbg), int'(DEAD));
    q_chk("t4b.head_frozen", 35, 25, 1, 0);

    // Test 6b: grow to MAX_LEN, then eat once more
    restart();
    chk("t6b.left_dead", int'(state_dbg), int'(RUN));
    set_btn(4'b1000);
    eat0 = eat_cnt;
    for (int i = 0; i < MAX_LEN - 1; i++) begin
      set_apple(33 + i, 24);
      do_tick();
    end
    chk("t6b.full_length", int'(length), MAX_LEN);
    chk("t6b.eats", eat_cnt - eat0, MAX_LEN - 1);
    q_chk("t6b.tail_full", 32, 24, 0, 1);
    eat0 = eat_cnt;
    set_apple(48, 24);
    do_tick();
    set_apple(0, 0);
    chk("t6b.saturated", int'(length), MAX_LEN);
    chk("t6b.pulse_at_max", eat_cnt - eat0, 1);
    chk("t6b.alive", int'(game_over), 0);
    qtab.push_back('{48, 24, 1, 0});
    qtab.push_back('{33, 24, 0, 1});
    qtab.push_back('{32, 24, 0, 0});
    run_qtab("t6b.q");

    chk("pulse_in_move", eat_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
